cic_decimator: RTL

- Parametrised decimating CIC filter with runtime-selectable decimation ratio and input-valid handshake, running on a single clock.
- The decimated rate is produced by an internal sample counter and flagged with a per-sample valid pulse. No second clock is used.
- Sits in the front-end channel path after the mixer and feeds the downstream compensation FIR.
- Order N, input width and maximum ratio are elaboration-time parameters.

---
 rtl/cic_decimator.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cic_decimator.sv
// Decimating CIC filter: N pipelined integrators at the input rate, a sample
// counter that marks the decimation event, and N token-driven comb stages
// with unit differential delay. Full-precision output, modular arithmetic.
module cic_decimator #(
  parameter int WIDTH = 16,
  parameter int N     = 3,
  parameter int RMAX  = 64
) (
  input  logic                                          clk_in,
  input  logic                                          reset,
  input  logic [$clog2(RMAX):0]                         rate,
  input  logic                                          in_valid,
  input  logic signed [WIDTH-1:0]                       in,
  output logic                                          out_valid,
  output logic signed [WIDTH+N*$clog2(RMAX)-1:0]        out,
  output logic                                          frame_start
);

  localparam int GROWTH = N * $clog2(RMAX);
  localparam int OW     = WIDTH + GROWTH;
  localparam int CW     = $clog2(RMAX);
  localparam int RW     = CW + 1;
  localparam logic [RW-1:0] RMAX_R = RW'(RMAX);
  localparam logic [RW-1:0] ONE_R  = RW'(1);

  // Map the requested ratio onto the supported range: 0 behaves as 1 and
  // anything above RMAX is clamped, so the counter can never overrun.
  function automatic logic [RW-1:0] decode_rate(input logic [RW-1:0] r);
    logic [RW-1:0] res;
    if (r == '0) begin
      res = ONE_R;
    end else if (r > RMAX_R) begin
      res = RMAX_R;
    end else begin
      res = r;
    end
    return res;
  endfunction

  // Integrator state
  logic signed [OW-1:0] integ_q [N];
  logic signed [OW-1:0] integ_d [N];

  // Comb state: index 0 is the captured decimated sample, 1..N are comb outputs
  logic signed [OW-1:0] comb_q [N+1];
  logic signed [OW-1:0] comb_d [N+1];
  logic signed [OW-1:0] dly_q  [N];
  logic signed [OW-1:0] dly_d  [N];
  logic [N:0]           vld_q;
  logic [N:0]           vld_d;

  // Rate control
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [RW-1:0]        r_eff_q;
  logic [RW-1:0]        r_eff_d;
  logic                 reload_q;
  logic                 reload_d;

  logic [RW-1:0]        r_eff;
  logic                 last_in_frame;
  logic                 dec_event;
  logic signed [OW-1:0] in_ext;

  // Until the first sample after reset is accepted the ratio follows the
  // rate input directly, which is how the reset-time value is picked up.
  assign r_eff         = reload_q ? decode_rate(rate) : r_eff_q;
  assign last_in_frame = ({1'b0, cnt_q} == (r_eff - ONE_R));
  assign dec_event     = in_valid && last_in_frame;
  assign in_ext        = {{GROWTH{in[WIDTH-1]}}, in};

  assign frame_start   = in_valid && (cnt_q == '0);
  assign out_valid     = vld_q[N];
  assign out           = comb_q[N];

  // Sample counter and ratio latch: the ratio is re-read only at a frame end
  always_comb begin
    cnt_d    = cnt_q;
    r_eff_d  = r_eff_q;
    reload_d = reload_q && !in_valid;
    if (in_valid) begin
      if (last_in_frame) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (reload_q || dec_event) begin
      r_eff_d = decode_rate(rate);
    end
  end

  // Integrator cascade: each stage adds the previous stage's registered value
  always_comb begin
    integ_d = integ_q;
    if (in_valid) begin
      integ_d[0] = integ_q[0] + in_ext;
      for (int k = 1; k < N; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
    end
  end

  // Comb cascade: a token enters on the decimation event and advances one
  // stage per clock, independent of in_valid
  always_comb begin
    comb_d   = comb_q;
    dly_d    = dly_q;
    vld_d    = '0;
    vld_d[0] = dec_event;
    if (dec_event) begin
      comb_d[0] = integ_q[N-1];
    end
    for (int k = 1; k <= N; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        comb_d[k]  = comb_q[k-1] - dly_q[k-1];
        dly_d[k-1] = comb_q[k-1];
      end
    end
  end

  // Control registers
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      r_eff_q  <= ONE_R;
      reload_q <= 1'b1;
      vld_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      r_eff_q  <= r_eff_d;
      reload_q <= reload_d;
      vld_q    <= vld_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      for (int k = 0; k <= N; k++) begin
        comb_q[k] <= '0;
      end
    end else begin
      integ_q <= integ_d;
      dly_q   <= dly_d;
      comb_q  <= comb_d;
    end
  end

endmodule
